operand_fetch: RTL and testbench

OPERAND_FETCH -- requirements
Module: operand_fetch

---
 rtl/riscv_32i_defs_pkg.sv | 26 ++
 rtl/of_scoreboard.sv | 28 ++
 rtl/operand_fetch.sv | 119 +++++++++++
 tb/tb_operand_fetch.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_32i_defs_pkg.sv
// Shared RV32I datapath types used by the operand fetch stage and its scoreboard.
package riscv_32i_defs_pkg;

  localparam int NUM_REGS = 32;

  typedef logic [4:0]  rf_addr_t;
  typedef logic [31:0] word_t;

  typedef struct packed {
    word_t    op1;
    word_t    op2;
    word_t    pc;
    word_t    imm;
    rf_addr_t rd;
    logic     rd_wr;
  } of_pkt_t;

  // x0 never maps to a bit, so x0 can never become busy
  function automatic logic [NUM_REGS-1:0] reg_onehot(input rf_addr_t r, input logic en);
    logic [NUM_REGS-1:0] m;
    m = '0;
    if (en && r != '0) m[r] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/of_scoreboard.sv
// Register busy scoreboard: set on issue, cleared by writeback or by flushing a held writer.
module of_scoreboard
  import riscv_32i_defs_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                set_en,
  input  logic [4:0]          set_reg,
  input  logic                clr_en,
  input  logic [4:0]          clr_reg,
  input  logic                fl_en,
  input  logic [4:0]          fl_reg,
  output logic [NUM_REGS-1:0] busy
);

  logic [NUM_REGS-1:0] set_mask, clr_mask, fl_mask;

  assign set_mask = reg_onehot(set_reg, set_en);
  assign clr_mask = reg_onehot(clr_reg, clr_en);
  assign fl_mask  = reg_onehot(fl_reg,  fl_en);

  // set applied last so a same-cycle set beats any clear
  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= (busy & ~clr_mask & ~fl_mask) | set_mask;
  end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: RF read, RAW/WAW hazard stall, one-entry output register.
// Define OPERAND_FETCH_BYPASS_EN to forward same-cycle writeback data to waiting consumers.
module operand_fetch
  import riscv_32i_defs_pkg::*;
#(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4:0]             in_rs1,
  input  logic [4:0]             in_rs2,
  input  logic [4:0]             in_rd,
  input  logic                   in_rd_wr,
  input  logic [31:0]            in_pc,
  input  logic [31:0]            in_imm,
  output logic [4:0]             rf_rd_reg_1,
  output logic [4:0]             rf_rd_reg_2,
  input  logic [31:0]            rf_rd_data_1,
  input  logic [31:0]            rf_rd_data_2,
  input  logic                   wb_en,
  input  logic [4:0]             wb_reg,
  input  logic [31:0]            wb_data,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_op1,
  output logic [31:0]            out_op2,
  output logic [31:0]            out_pc,
  output logic [31:0]            out_imm,
  output logic [4:0]             out_rd,
  output logic                   out_rd_wr,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  logic [NUM_REGS-1:0] busy, eff_busy;
  logic [1:0][4:0]     rs;
  logic [1:0][31:0]    rf_data, op;
  logic [1:0]          raw, byp;
  logic                waw, hazard, issue;
  of_pkt_t             pkt, out_q;

  assign rf_rd_reg_1 = in_rs1;
  assign rf_rd_reg_2 = in_rs2;
  assign rs      = {in_rs2, in_rs1};
  assign rf_data = {rf_rd_data_2, rf_rd_data_1};

`ifdef OPERAND_FETCH_BYPASS_EN
  assign eff_busy = busy & ~reg_onehot(wb_reg, wb_en);
`else
  assign eff_busy = busy;
`endif

  for (genvar g = 0; g < 2; g++) begin : g_src
    assign raw[g] = (rs[g] != '0) && eff_busy[rs[g]];
`ifdef OPERAND_FETCH_BYPASS_EN
    assign byp[g] = wb_en && (wb_reg == rs[g]) && (rs[g] != '0);
`else
    assign byp[g] = 1'b0;
`endif
    assign op[g] = (rs[g] == '0) ? '0 : (byp[g] ? wb_data : rf_data[g]);
  end

  assign waw      = in_rd_wr && (in_rd != '0) && eff_busy[in_rd];
  assign hazard   = (|raw) || waw;
  assign in_ready = !hazard && !flush && (!out_valid || out_ready);
  assign issue    = in_valid && in_ready;

  always_comb begin
    pkt       = '0;
    pkt.op1   = op[0];
    pkt.op2   = op[1];
    pkt.pc    = in_pc;
    pkt.imm   = in_imm;
    pkt.rd    = in_rd;
    pkt.rd_wr = in_rd_wr;
  end

  // data only moves on issue, so a stalled output holds stable
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q     <= '0;
      out_valid <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (issue) begin
      out_q     <= pkt;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                                        stall_cnt <= '0;
    else if (in_valid && hazard && stall_cnt != '1) stall_cnt <= stall_cnt + STALL_CNT_W'(1);
  end

  assign out_op1   = out_q.op1;
  assign out_op2   = out_q.op2;
  assign out_pc    = out_q.pc;
  assign out_imm   = out_q.imm;
  assign out_rd    = out_q.rd;
  assign out_rd_wr = out_q.rd_wr;

  of_scoreboard u_sb (
    .clk     (clk),
    .rst     (rst),
    .set_en  (issue && in_rd_wr),
    .set_reg (in_rd),
    .clr_en  (wb_en),
    .clr_reg (wb_reg),
    .fl_en   (flush && out_valid && out_q.rd_wr),
    .fl_reg  (out_q.rd),
    .busy    (busy)
  );

endmodule

// File: tb/tb_operand_fetch.sv
// Directed self-checking bench for operand_fetch (either bypass build).
module tb_operand_fetch;

  localparam int SCW = 4;
`ifdef OPERAND_FETCH_BYPASS_EN
  localparam int XB = 0;
`else
  localparam int XB = 1;
`endif

  logic clk = 1'b0, rst;
  logic in_valid, in_ready, in_rd_wr, wb_en, flush, out_valid, out_ready, out_rd_wr;
  logic [4:0]  in_rs1, in_rs2, in_rd, rf_rd_reg_1, rf_rd_reg_2, wb_reg, out_rd;
  logic [31:0] in_pc, in_imm, rf_rd_data_1, rf_rd_data_2, wb_data;
  logic [31:0] out_op1, out_op2, out_pc, out_imm;
  logic [SCW-1:0] stall_cnt;
  logic [31:0] rf [32];
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  operand_fetch #(.STALL_CNT_W(SCW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_wr(in_rd_wr),
    .in_pc(in_pc), .in_imm(in_imm), .rf_rd_reg_1(rf_rd_reg_1), .rf_rd_reg_2(rf_rd_reg_2),
    .rf_rd_data_1(rf_rd_data_1), .rf_rd_data_2(rf_rd_data_2),
    .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_op1(out_op1), .out_op2(out_op2),
    .out_pc(out_pc), .out_imm(out_imm), .out_rd(out_rd), .out_rd_wr(out_rd_wr),
    .stall_cnt(stall_cnt)
  );

  // RF model; x0 deliberately returns all-ones so the stage must force zero
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'h11 * i;
      rf[0] <= 32'hFFFF_FFFF;
    end else if (wb_en && wb_reg != 5'd0) rf[wb_reg] <= wb_data;
  end
  assign rf_rd_data_1 = rf[rf_rd_reg_1];
  assign rf_rd_data_2 = rf[rf_rd_reg_2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] rd, input logic wr, input logic [31:0] pc);
    in_valid = v; in_rs1 = r1; in_rs2 = r2; in_rd = rd; in_rd_wr = wr;
    in_pc = pc; in_imm = pc ^ 32'hA5;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    wb_en = 1'b0; wb_reg = '0; wb_data = '0;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0);
    tick; tick;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_stall", {28'd0, stall_cnt}, 32'd0);
    chk("rst_busy",  dut.u_sb.busy, 32'd0);
    chk("rst_op1",   out_op1, 32'd0);
    rst = 1'b0;

    // basic issue
    drive(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 32'h100);
    #1;
    chk("rd_reg_1", {27'd0, rf_rd_reg_1}, 32'd1);
    chk("rd_reg_2", {27'd0, rf_rd_reg_2}, 32'd2);
    chk("rdy_basic", {31'd0, in_ready}, 32'd1);
    tick;
    in_valid = 1'b0;
    chk("basic_valid", {31'd0, out_valid}, 32'd1);
    chk("basic_op1", out_op1, 32'h11);
    chk("basic_op2", out_op2, 32'h22);
    chk("basic_imm", out_imm, 32'h100 ^ 32'hA5);
    chk("basic_busy3", {31'd0, dut.u_sb.busy[3]}, 32'd1);
    tick;
    chk("drop_valid", {31'd0, out_valid}, 32'd0);
    wb_en = 1'b1; wb_reg = 5'd3; wb_data = 32'h333;
    tick;
    wb_en = 1'b0;
    chk("wb_clr3", dut.u_sb.busy, 32'd0);

    // RAW stall on x5, released by writeback
    drive(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 32'h104);
    tick;
    drive(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 32'h108);
    #1 chk("raw_rdy", {31'd0, in_ready}, 32'd0);
    tick; tick; tick;
    chk("raw_stall3", {28'd0, stall_cnt}, 32'd3);
    wb_en = 1'b1; wb_reg = 5'd5; wb_data = 32'hDEAD;
    #1 chk("raw_wb_rdy", {31'd0, in_ready}, 32'(1 - XB));
`ifdef OPERAND_FETCH_BYPASS_EN
    tick; wb_en = 1'b0;
`else
    tick; wb_en = 1'b0;
    #1 chk("raw_late_rdy", {31'd0, in_ready}, 32'd1);
    tick;
`endif
    chk("raw_op1", out_op1, 32'hDEAD);
    chk("raw_pc", out_pc, 32'h108);
    chk("raw_stall", {28'd0, stall_cnt}, 32'(3 + XB));
    chk("raw_busy", dut.u_sb.busy, 32'h40);

    // backpressure hold, then back-to-back issue
    out_ready = 1'b0;
    drive(1'b1, 5'd1, 5'd2, 5'd0, 1'b0, 32'h200);
    #1 chk("bp_rdy", {31'd0, in_ready}, 32'd0);
    tick; tick; tick;
    chk("bp_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_pc", out_pc, 32'h108);
    chk("bp_op1", out_op1, 32'hDEAD);
    chk("bp_rdy3", {31'd0, in_ready}, 32'd0);
    chk("bp_stall", {28'd0, stall_cnt}, 32'(3 + XB));
    out_ready = 1'b1;
    #1 chk("bp_release", {31'd0, in_ready}, 32'd1);
    tick;
    chk("b2b_pc0", out_pc, 32'h200);
    chk("b2b_op2", out_op2, 32'h22);
    drive(1'b1, 5'd2, 5'd1, 5'd0, 1'b0, 32'h204);
    tick;
    chk("b2b_pc1", out_pc, 32'h204);
    chk("b2b_op1", out_op1, 32'h22);
    chk("b2b_valid", {31'd0, out_valid}, 32'd1);

    // x0 source ignores both wb to x0 and RF contents
    drive(1'b1, 5'd0, 5'd1, 5'd0, 1'b0, 32'h300);
    wb_en = 1'b1; wb_reg = 5'd0; wb_data = 32'hFFFF_FFFF;
    #1 chk("x0_rdy", {31'd0, in_ready}, 32'd1);
    tick;
    wb_en = 1'b0;
    chk("x0_op1", out_op1, 32'd0);
    chk("x0_op2", out_op2, 32'h11);
    chk("x0_stall", {28'd0, stall_cnt}, 32'(3 + XB));

    // WAW on x7
    drive(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 32'h304);
    tick;
    drive(1'b1, 5'd1, 5'd0, 5'd7, 1'b1, 32'h308);
    #1 chk("waw_rdy", {31'd0, in_ready}, 32'd0);
    tick; tick;
    wb_en = 1'b1; wb_reg = 5'd7; wb_data = 32'h777;
`ifdef OPERAND_FETCH_BYPASS_EN
    tick; wb_en = 1'b0;
`else
    tick; wb_en = 1'b0;
    tick;
`endif
    chk("waw_pc", out_pc, 32'h308);
    chk("waw_busy7", {31'd0, dut.u_sb.busy[7]}, 32'd1);
    chk("waw_stall", {28'd0, stall_cnt}, 32'(5 + 2 * XB));
    in_valid = 1'b0;
    wb_en = 1'b1; wb_reg = 5'd7;
    tick;
    wb_en = 1'b0;
    chk("waw_clr", dut.u_sb.busy, 32'h40);

    // flush of a held writer to x9 keeps x10 and x6 busy
    drive(1'b1, 5'd0, 5'd0, 5'd10, 1'b1, 32'h400);
    tick;
    drive(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 32'h404);
    tick;
    in_valid = 1'b0; out_ready = 1'b0;
    tick;
    chk("fl_hold_rd", {27'd0, out_rd}, 32'd9);
    chk("fl_busy_pre", dut.u_sb.busy, 32'h640);
    flush = 1'b1;
    #1 chk("fl_rdy", {31'd0, in_ready}, 32'd0);
    tick;
    flush = 1'b0; out_ready = 1'b1;
    chk("fl_valid", {31'd0, out_valid}, 32'd0);
    chk("fl_busy", dut.u_sb.busy, 32'h440);

    // saturation: 16 more stalls on busy x10
    drive(1'b1, 5'd10, 5'd0, 5'd0, 1'b0, 32'h500);
    repeat (16) tick;
    chk("sat_cnt", {28'd0, stall_cnt}, 32'd15);
    chk("sat_rdy", {31'd0, in_ready}, 32'd0);

    // reset mid-stall discards the pending instruction
    rst = 1'b1;
    tick;
    rst = 1'b0; in_valid = 1'b0;
    chk("rst2_valid", {31'd0, out_valid}, 32'd0);
    chk("rst2_busy", dut.u_sb.busy, 32'd0);
    chk("rst2_stall", {28'd0, stall_cnt}, 32'd0);
    chk("rst2_pc", out_pc, 32'd0);
    chk("rst2_rd", {26'd0, out_rd_wr, out_rd}, 32'd0);
    tick;
    chk("rst2_noout", {31'd0, out_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
